// File: rtl/vga_screen_mux_pkg.sv
// Shared types and constants for the VGA screen source mux.
package screen_pkg;

  typedef enum logic [1:0] {STEADY, PENDING, BLANK} mux_state_e;

  typedef enum logic [3:0] {
    SM = 4'hF, LS = 4'h1, GO = 4'h2,
    L1 = 4'h3, L2 = 4'h4, L3 = 4'h5, L4 = 4'h6,
    L5 = 4'h7, L6 = 4'h8, L7 = 4'h9, L8 = 4'hA
  } screen_e;

  // Idle sync level is the inactive level: high for active-low syncs.
  function automatic logic sync_idle(input bit active_low);
    return active_low;
  endfunction

  localparam logic SYNC_IDLE_DEFAULT = sync_idle(1'b1);

endpackage

// File: rtl/vga_screen_mux_if.sv
// VGA source bundle in, board VGA pins out.
interface vga_screen_mux_if #(
  parameter int N_SRC   = 4,
  parameter int COLOR_W = 4
);
  localparam int SEL_W = $clog2(N_SRC);

  logic [SEL_W-1:0]         sel;
  logic [N_SRC*COLOR_W-1:0] src_r, src_g, src_b;
  logic [N_SRC-1:0]         src_hs, src_vs;
  logic [COLOR_W-1:0]       VGA_R, VGA_G, VGA_B;
  logic                     VGA_HS, VGA_VS;
  logic [SEL_W-1:0]         active_src;
  logic                     switching;

  modport master (
    output sel, src_r, src_g, src_b, src_hs, src_vs,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, active_src, switching
  );

  modport slave (
    input  sel, src_r, src_g, src_b, src_hs, src_vs,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, active_src, switching
  );
endinterface

// File: rtl/vga_screen_mux_sync_edge_det.sv
// Assertion-edge detector for a sync line, with a preload so a freshly
// selected source does not produce a spurious edge.
module sync_edge_det import screen_pkg::*; #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  input  logic load,
  input  logic load_val,
  output logic trig
);
  localparam logic IDLE = sync_idle(SYNC_ACTIVE_LOW);

  logic prev_vs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_vs <= IDLE;
    else        prev_vs <= load ? load_val : sig;
  end

  assign trig = (prev_vs == IDLE) && (sig != IDLE);
endmodule

// File: rtl/vga_screen_mux.sv
// Registered N-way VGA source mux; switches only on a VS assertion edge
// (or timeout) and optionally blanks colour for a few frames afterwards.
module vga_screen_mux import screen_pkg::*; #(
  parameter int N_SRC           = 4,
  parameter int COLOR_W         = 4,
  parameter int SEL_W           = $clog2(N_SRC),
  parameter int RESET_SRC       = 0,
  parameter int BLANK_FRAMES    = 1,
  parameter int TIMEOUT         = 2_000_000,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  vga_screen_mux_if.slave bus
);
  localparam logic           IDLE   = sync_idle(SYNC_ACTIVE_LOW);
  localparam int             TW     = $clog2(TIMEOUT + 1);
  localparam int             BW     = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0]  B_LAST = BW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

  mux_state_e         state;
  logic [SEL_W-1:0]   active;
  logic [TW-1:0]      tcnt;
  logic [BW-1:0]      bcnt;

  logic               sel_ok, vs_cur, vs_edge, tout, take, blank_end, col_zero;
  logic [SEL_W-1:0]   out_idx;
  logic [COLOR_W-1:0] r_mux, g_mux, b_mux;
  logic               hs_mux, vs_mux;

  assign sel_ok    = {1'b0, bus.sel} < (SEL_W + 1)'(N_SRC);
  assign tout      = (tcnt == T_LAST);
  // The switch always lands on the currently sampled sel, so a retarget or a
  // same-cycle sel change needs no separate target register.
  assign take      = sel_ok && (state == PENDING) && (bus.sel != active) && (vs_edge || tout);
  assign blank_end = (state == BLANK) && (tout || (vs_edge && bcnt == B_LAST));
  // Outputs select on the next active index so the new source appears on the
  // very first cycle after the edge.
  assign out_idx   = take ? bus.sel : active;
  assign col_zero  = !sel_ok || (take ? (BLANK_FRAMES > 0) : (state == BLANK && !blank_end));

  always_comb begin
    r_mux  = '0;
    g_mux  = '0;
    b_mux  = '0;
    hs_mux = IDLE;
    vs_mux = IDLE;
    vs_cur = IDLE;
    for (int k = 0; k < N_SRC; k++) begin
      if (out_idx == SEL_W'(k)) begin
        r_mux  = bus.src_r[k*COLOR_W +: COLOR_W];
        g_mux  = bus.src_g[k*COLOR_W +: COLOR_W];
        b_mux  = bus.src_b[k*COLOR_W +: COLOR_W];
        hs_mux = bus.src_hs[k];
        vs_mux = bus.src_vs[k];
      end
      if (active == SEL_W'(k)) vs_cur = bus.src_vs[k];
    end
  end

  sync_edge_det #(.SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig      (vs_cur),
    .load     (take),
    .load_val (vs_mux),
    .trig     (vs_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= STEADY;
      active        <= SEL_W'(RESET_SRC);
      tcnt          <= '0;
      bcnt          <= '0;
      bus.switching <= 1'b0;
      bus.VGA_R     <= '0;
      bus.VGA_G     <= '0;
      bus.VGA_B     <= '0;
      bus.VGA_HS    <= IDLE;
      bus.VGA_VS    <= IDLE;
    end else begin
      bus.VGA_R  <= col_zero ? '0 : r_mux;
      bus.VGA_G  <= col_zero ? '0 : g_mux;
      bus.VGA_B  <= col_zero ? '0 : b_mux;
      bus.VGA_HS <= sel_ok ? hs_mux : IDLE;
      bus.VGA_VS <= sel_ok ? vs_mux : IDLE;
      // An invalid select freezes the FSM and both counters.
      if (sel_ok) begin
        case (state)
          STEADY: if (bus.sel != active) begin
            state         <= PENDING;
            tcnt          <= '0;
            bus.switching <= 1'b1;
          end
          PENDING: begin
            if (tcnt != '1) tcnt <= tcnt + 1'b1;
            if (bus.sel == active) begin
              state         <= STEADY;
              bus.switching <= 1'b0;
            end else if (take) begin
              active        <= bus.sel;
              bcnt          <= '0;
              state         <= (BLANK_FRAMES > 0) ? BLANK : STEADY;
              bus.switching <= (BLANK_FRAMES > 0);
            end
          end
          BLANK: begin
            if (tcnt != '1) tcnt <= tcnt + 1'b1;
            if (vs_edge) bcnt <= bcnt + 1'b1;
            if (blank_end) begin
              state         <= STEADY;
              bus.switching <= 1'b0;
            end
          end
          default: state <= STEADY;
        endcase
      end
    end
  end

  assign bus.active_src = active;
endmodule

// File: tb/tb_vga_screen_mux.sv
// Directed bench: three mux configurations sharing one clock and reset.
module tb_vga_screen_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  vga_screen_mux_if #(.N_SRC(4), .COLOR_W(4)) ia ();
  vga_screen_mux_if #(.N_SRC(4), .COLOR_W(4)) ib ();
  vga_screen_mux_if #(.N_SRC(3), .COLOR_W(4)) ic ();

  vga_screen_mux #(.N_SRC(4), .COLOR_W(4), .RESET_SRC(0), .BLANK_FRAMES(0), .TIMEOUT(100))
    ua (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  vga_screen_mux #(.N_SRC(4), .COLOR_W(4), .RESET_SRC(1), .BLANK_FRAMES(2), .TIMEOUT(1000))
    ub (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  vga_screen_mux #(.N_SRC(3), .COLOR_W(4), .RESET_SRC(0), .BLANK_FRAMES(1), .TIMEOUT(1000))
    uc (.clk(clk), .rst_n(rst_n), .bus(ic.slave));

  typedef struct {
    int         sel;
    logic [3:0] hs;
    logic [3:0] vs;
    int         exp_src;  // -1 = black
    logic [1:0] exp_hv;   // {HS, VS}
    int         exp_act;
    logic       exp_sw;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [11:0] col(input int i, input int k);
    return {4'(i + k), 4'(i * 3 + k), 4'(k * 5 + i + 1)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input int i);
    logic [11:0] c;
    for (int k = 0; k < 4; k++) begin
      c = col(i, k);
      ia.src_r[k*4 +: 4] = c[11:8];
      ia.src_g[k*4 +: 4] = c[7:4];
      ia.src_b[k*4 +: 4] = c[3:0];
    end
  endtask

  task automatic drv_b(input int i);
    logic [11:0] c;
    for (int k = 0; k < 4; k++) begin
      c = col(i, k);
      ib.src_r[k*4 +: 4] = c[11:8];
      ib.src_g[k*4 +: 4] = c[7:4];
      ib.src_b[k*4 +: 4] = c[3:0];
    end
  endtask

  task automatic drv_c(input int i);
    logic [11:0] c;
    for (int k = 0; k < 3; k++) begin
      c = col(i, k);
      ic.src_r[k*4 +: 4] = c[11:8];
      ic.src_g[k*4 +: 4] = c[7:4];
      ic.src_b[k*4 +: 4] = c[3:0];
    end
  endtask

  task automatic chk_b(input string nm, input logic [11:0] c, input logic [1:0] hv,
                       input int act, input logic sw);
    chk({nm, " colour"}, {ib.VGA_R, ib.VGA_G, ib.VGA_B}, c);
    chk({nm, " sync"},   {ib.VGA_HS, ib.VGA_VS}, hv);
    chk({nm, " active"}, ib.active_src, act);
    chk({nm, " switching"}, ib.switching, sw);
  endtask

  task automatic chk_c(input string nm, input logic [11:0] c, input logic [1:0] hv,
                       input int act, input logic sw);
    chk({nm, " colour"}, {ic.VGA_R, ic.VGA_G, ic.VGA_B}, c);
    chk({nm, " sync"},   {ic.VGA_HS, ic.VGA_VS}, hv);
    chk({nm, " active"}, ic.active_src, act);
    chk({nm, " switching"}, ic.switching, sw);
  endtask

  initial begin
    //        sel  hs     vs     src hv     act sw
    vecs[0]  = '{0, 4'hF, 4'hF, 0, 2'b11, 0, 1'b0};
    vecs[1]  = '{0, 4'h0, 4'hF, 0, 2'b01, 0, 1'b0};
    vecs[2]  = '{2, 4'hF, 4'hF, 0, 2'b11, 0, 1'b1};
    vecs[3]  = '{2, 4'hF, 4'hF, 0, 2'b11, 0, 1'b1};
    vecs[4]  = '{2, 4'hF, 4'hB, 0, 2'b11, 0, 1'b1};
    vecs[5]  = '{2, 4'hF, 4'hE, 2, 2'b11, 2, 1'b0};
    vecs[6]  = '{2, 4'hF, 4'hF, 2, 2'b11, 2, 1'b0};
    vecs[7]  = '{3, 4'hF, 4'hF, 2, 2'b11, 2, 1'b1};
    vecs[8]  = '{1, 4'hF, 4'hF, 2, 2'b11, 2, 1'b1};
    vecs[9]  = '{1, 4'hF, 4'hB, 1, 2'b11, 1, 1'b0};
    vecs[10] = '{1, 4'hF, 4'hF, 1, 2'b11, 1, 1'b0};
    vecs[11] = '{3, 4'hF, 4'hF, 1, 2'b11, 1, 1'b1};
    vecs[12] = '{0, 4'hF, 4'hD, 0, 2'b11, 0, 1'b0};
    vecs[13] = '{0, 4'hF, 4'hF, 0, 2'b11, 0, 1'b0};
    vecs[14] = '{1, 4'hF, 4'hF, 0, 2'b11, 0, 1'b1};
    vecs[15] = '{0, 4'hF, 4'hF, 0, 2'b11, 0, 1'b0};
    vecs[16] = '{0, 4'hF, 4'hE, 0, 2'b10, 0, 1'b0};
    vecs[17] = '{0, 4'hF, 4'hF, 0, 2'b11, 0, 1'b0};

    // Reset held with random inputs.
    repeat (3) begin
      ia.sel = 2'($urandom()); ia.src_r = 16'($urandom()); ia.src_g = 16'($urandom());
      ia.src_b = 16'($urandom()); ia.src_hs = 4'($urandom()); ia.src_vs = 4'($urandom());
      ib.sel = 2'($urandom()); ib.src_r = 16'($urandom()); ib.src_g = 16'($urandom());
      ib.src_b = 16'($urandom()); ib.src_hs = 4'($urandom()); ib.src_vs = 4'($urandom());
      ic.sel = 2'($urandom()); ic.src_r = 12'($urandom()); ic.src_g = 12'($urandom());
      ic.src_b = 12'($urandom()); ic.src_hs = 3'($urandom()); ic.src_vs = 3'($urandom());
      step();
      chk("rst A colour", {ia.VGA_R, ia.VGA_G, ia.VGA_B}, 12'h000);
      chk("rst A sync", {ia.VGA_HS, ia.VGA_VS}, 2'b11);
      chk("rst A active", ia.active_src, 0);
      chk("rst A switching", ia.switching, 1'b0);
      chk_b("rst B", 12'h000, 2'b11, 1, 1'b0);
      chk_c("rst C", 12'h000, 2'b11, 0, 1'b0);
    end

    ia.sel = 0; ia.src_hs = 4'hF; ia.src_vs = 4'hF; drv_a(0);
    ib.sel = 1; ib.src_hs = 4'hF; ib.src_vs = 4'hF; drv_b(7);
    ic.sel = 0; ic.src_hs = 3'h7; ic.src_vs = 3'h7; drv_c(9);
    rst_n = 1'b1;

    // Bus A: frame-aligned switch, retarget, simultaneous change, cancel.
    for (int i = 0; i < 18; i++) begin
      logic [11:0] ec;
      ia.sel = 2'(vecs[i].sel); ia.src_hs = vecs[i].hs; ia.src_vs = vecs[i].vs;
      drv_a(i);
      step();
      ec = (vecs[i].exp_src < 0) ? 12'h000 : col(i, vecs[i].exp_src);
      chk($sformatf("vec%0d colour", i), {ia.VGA_R, ia.VGA_G, ia.VGA_B}, ec);
      chk($sformatf("vec%0d sync", i), {ia.VGA_HS, ia.VGA_VS}, vecs[i].exp_hv);
      chk($sformatf("vec%0d active", i), ia.active_src, vecs[i].exp_act);
      chk($sformatf("vec%0d switching", i), ia.switching, vecs[i].exp_sw);
    end

    // Bus A: VS held idle, switch forced by the 100-cycle timeout.
    ia.src_hs = 4'hF; ia.src_vs = 4'hF; drv_a(50);
    ia.sel = 1;
    step();
    chk("timeout enter switching", ia.switching, 1'b1);
    repeat (99) step();
    chk("timeout before active", ia.active_src, 0);
    chk("timeout before switching", ia.switching, 1'b1);
    step();
    chk("timeout at active", ia.active_src, 1);
    chk("timeout at switching", ia.switching, 1'b0);
    chk("timeout at colour", {ia.VGA_R, ia.VGA_G, ia.VGA_B}, col(50, 1));

    // Bus B: switch 1->3 with two blanked frames.
    ib.sel = 3;                           step(); chk_b("B pend",  col(7, 1), 2'b11, 1, 1'b1);
    ib.src_vs = 4'hD;                     step(); chk_b("B swap",  12'h000,   2'b11, 3, 1'b1);
    ib.src_vs = 4'hF; ib.src_hs = 4'h0;   step(); chk_b("B blk0",  12'h000,   2'b01, 3, 1'b1);
    ib.src_vs = 4'h7; ib.src_hs = 4'hF;   step(); chk_b("B edge1", 12'h000,   2'b10, 3, 1'b1);
    ib.src_vs = 4'hF;                     step(); chk_b("B blk1",  12'h000,   2'b11, 3, 1'b1);
    ib.src_vs = 4'h7;                     step(); chk_b("B edge2", col(7, 3), 2'b10, 3, 1'b0);
    ib.src_vs = 4'hF;                     step(); chk_b("B steady", col(7, 3), 2'b11, 3, 1'b0);

    // Bus C: invalid select, then a normal switch with one blank frame.
    ic.sel = 3; ic.src_hs = 3'h0; ic.src_vs = 3'h0; step(); chk_c("C inv0", 12'h000, 2'b11, 0, 1'b0);
    step();                                               chk_c("C inv1", 12'h000, 2'b11, 0, 1'b0);
    ic.sel = 1; ic.src_hs = 3'h7; ic.src_vs = 3'h7; step(); chk_c("C pend", col(9, 0), 2'b11, 0, 1'b1);
    ic.src_vs = 3'h6;                               step(); chk_c("C swap", 12'h000, 2'b11, 1, 1'b1);
    ic.src_vs = 3'h5;                               step(); chk_c("C done", col(9, 1), 2'b10, 1, 1'b0);

    // Asynchronous reset in the middle of a pending switch.
    ia.sel = 2;
    step();
    chk("midrst pre switching", ia.switching, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst switching", ia.switching, 1'b0);
    chk("midrst active", ia.active_src, 0);
    chk("midrst colour", {ia.VGA_R, ia.VGA_G, ia.VGA_B}, 12'h000);
    chk("midrst sync", {ia.VGA_HS, ia.VGA_VS}, 2'b11);
    chk_b("midrst B", 12'h000, 2'b11, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_screen_mux.md
# vga_screen_mux

Parametrised, registered VGA source selector sitting between the screen drivers (menu, level select, game over, game levels) and the board VGA pins. It replaces the combinational per-state mux with an N-channel mux that switches sources only at a vertical-sync boundary, blanks colour for a programmable number of frames after a switch, and force-switches if the current source stops producing sync. All outputs are registered, so the VGA pins are glitch-free.

## Interface
- `N_SRC`, 4: number of VGA sources; must be ≥ 2.
- `COLOR_W`, 4: bits per colour channel.
- `SEL_W`, `$clog2(N_SRC)`: select width; derived, do not override.
- `RESET_SRC`, 0: source index made active at reset.
- `BLANK_FRAMES`, 1: frames of forced-black colour after a switch; 0 disables blanking.
- `TIMEOUT`, 2_000_000: cycles to wait for a VS edge before forcing the switch. Exceeds one 60 Hz frame at 100 MHz.
- `SYNC_ACTIVE_LOW`, 1: sync polarity. The idle level is 1 when this is set, otherwise 0.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `sel` in `SEL_W`: requested source index. Sampled every cycle.
- `src_r` / `src_g` / `src_b` in `N_SRC*COLOR_W`: packed colours. Source k occupies bits `[k*COLOR_W +: COLOR_W]`.
- `src_hs` / `src_vs` in `N_SRC`: per-source syncs.
- `VGA_R` / `VGA_G` / `VGA_B` out `COLOR_W`: registered colour.
- `VGA_HS` / `VGA_VS` out 1: registered syncs.
- `active_src` out `SEL_W`: source currently driving the outputs.
- `switching` out 1: high while in PENDING or BLANK.

## Operation
- **VS edge** means the assertion edge of the active source's VS:
  - falling edge when `SYNC_ACTIVE_LOW=1`;
  - detected as `prev_vs` at idle level and `src_vs[active_src]` at active level.
- **Invalid select:** `sel ≥ N_SRC` is invalid. Outputs go to colour 0 with syncs at idle level on the next cycle and `active_src` holds its value. No state transition occurs while `sel` is invalid.
- **States:**
  - STEADY: `sel` valid and `sel ≠ active_src` → latch `target=sel`, clear timeout counter, go to PENDING.
  - PENDING:
    - If `sel` changes to another valid index ≠ `active_src`, update `target`; the timeout counter is not cleared.
    - If `sel == active_src`, cancel and return to STEADY.
    - On a VS edge, or when the timeout counter reaches `TIMEOUT-1`: `active_src ← target` and `prev_vs ← src_vs[target]`, which suppresses a false edge from the new source. Then go to BLANK if `BLANK_FRAMES>0`, otherwise STEADY.
  - BLANK:
    - Colour is forced to 0; syncs still pass through.
    - Count VS edges of the new source. After `BLANK_FRAMES` edges, go to STEADY.
    - A `sel` change during BLANK is not lost: it is re-evaluated in STEADY on the next cycle.
    - The timeout counter also runs in BLANK. Reaching `TIMEOUT-1` ends BLANK.
- **Simultaneous events:** if a VS edge and a `sel` change occur in the same PENDING cycle, the switch uses the newly sampled `sel`, provided it is valid and ≠ `active_src`.
- **Counter width:** the timeout counter is `$clog2(TIMEOUT+1)` bits and saturates; it never wraps.

## Timing
- **Reset values:**
  - colour outputs 0;
  - `VGA_HS`/`VGA_VS` at idle level;
  - `active_src = RESET_SRC`;
  - `switching = 0`;
  - state STEADY;
  - counters 0;
  - `prev_vs` at idle level.
- **Latency:** one cycle from source pin to VGA pin, identical for colour and sync, so pixel alignment is preserved.
- **Switch point:** the first output cycle carrying the new source is the cycle after the VS edge is detected.
- **`switching`:** rises one cycle after the `sel` change. It falls on the cycle the state returns to STEADY.
- **Reset mid-operation:** an asynchronous clear at any point returns all state to reset values immediately. There is no partial-frame recovery.

## Structure
- **`screen_pkg`:**
  - FSM state enum (STEADY, PENDING, BLANK);
  - screen state encodings SM=4'hF, LS=4'h1, GO=4'h2, L1–L8=4'h3–4'hA;
  - sync-idle helper constant.
- **Sub-module `sync_edge_det`:** parametrised on polarity. Registers the previous value and supports a synchronous load for the post-switch preload. The mux FSM, blank counter and timeout counter stay in `vga_screen_mux`.

## Test plan
- **Reset:** hold `rst_n=0` with random inputs → colour 0, HS=VS=1, `active_src=0`, `switching=0`. Release and drive source 0 → outputs equal source 0 delayed one cycle.
- **Frame-aligned switch:** `N_SRC=4`, `BLANK_FRAMES=0`, `sel` 0→2 mid-frame → outputs stay on source 0 until its VS falling edge. The cycle after, outputs track source 2 and `active_src=2`.
- **Blanking:** `BLANK_FRAMES=2`, switch 1→3 → colour exactly 0 for two source-3 VS edges while syncs pass. Colour resumes on the cycle after the second edge.
- **Retarget and cancel:** during PENDING, `sel` 0→1→2 → the switch lands on 2. A separate run with `sel` 0→1→0 before the edge → `switching` drops and `active_src` stays 0.
- **Timeout:** `TIMEOUT=100`, source 0 VS held idle, `sel=1` → the switch happens exactly 100 cycles after entering PENDING.
- **Invalid select:** `N_SRC=3`, `sel=3` → black output with syncs idle and `active_src` unchanged. Returning to `sel=1` proceeds through a normal switch.
